// File: rtl/vga_timing_gen_if.sv
// Raster/pixel bus between the VGA timing generator and its pixel source / DAC pins.
// The generator is the master: it issues pixel requests and drives syncs and colour.
interface vga_timing_gen_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 10
);
    logic [7:0]    rgb_8;
    logic          pix_tick;
    logic          pixel_en;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          frame_start;
    logic          h_sync;
    logic          v_sync;
    logic          de_out;
    logic [7:0]    r_out;
    logic [7:0]    g_out;
    logic [7:0]    b_out;

    modport master (
        input  rgb_8,
        output pix_tick, pixel_en, pixel_x, pixel_y, frame_start,
        output h_sync, v_sync, de_out, r_out, g_out, b_out
    );

    modport slave (
        output rgb_8,
        input  pix_tick, pixel_en, pixel_x, pixel_y, frame_start,
        input  h_sync, v_sync, de_out, r_out, g_out, b_out
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, h/v counters, registered pixel-request decode
// and a one-clock output stage producing syncs, display enable and RGB888 from RGB332.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter bit          EXPAND   = 1'b0,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master bus
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DCW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HCW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VCW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam logic        SYNC_IDLE = ~SYNC_POL;

    logic [DCW-1:0] div_q, div_d;
    logic [HCW-1:0] h_q, h_d;
    logic [VCW-1:0] v_q, v_d;
    logic           tick;
    logic           h_act, v_act, pix_act, h_sync_act, v_sync_act, at_origin;

    logic           tick_q, fs_q, en_q, hs_pre_q, vs_pre_q;
    logic [XW-1:0]  x_q;
    logic [YW-1:0]  y_q;
    logic           de_q, hs_q, vs_q;
    logic [7:0]     r_q, g_q, b_q;

    logic [2:0]     r3, g3;
    logic [1:0]     b2;
    logic [7:0]     r_exp, g_exp, b_exp;

    // With CLK_DIV=1 the divider stays at 0 and every clock is a pixel tick.
    assign tick = (div_q == DCW'(CLK_DIV - 1));

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (32'(h_q) == H_TOTAL - 1) begin
                h_d = '0;
                v_d = (32'(v_q) == V_TOTAL - 1) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Decode of the position about to be issued on this tick.
    assign h_act      = 32'(h_q) < H_ACTIVE;
    assign v_act      = 32'(v_q) < V_ACTIVE;
    assign pix_act    = h_act & v_act;
    assign h_sync_act = (32'(h_q) >= HS_START) && (32'(h_q) < HS_END);
    assign v_sync_act = (32'(v_q) >= VS_START) && (32'(v_q) < VS_END);
    assign at_origin  = (h_q == '0) && (v_q == '0);

    assign {r3, g3, b2} = bus.rgb_8;
    assign r_exp = EXPAND ? {r3, r3, r3[2:1]} : {r3, 5'b0};
    assign g_exp = EXPAND ? {g3, g3, g3[2:1]} : {g3, 5'b0};
    assign b_exp = EXPAND ? {b2, b2, b2, b2} : {b2, 6'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            tick_q   <= 1'b0;
            fs_q     <= 1'b0;
            en_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            hs_pre_q <= 1'b0;
            vs_pre_q <= 1'b0;
            de_q     <= 1'b0;
            hs_q     <= SYNC_IDLE;
            vs_q     <= SYNC_IDLE;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            tick_q <= tick;
            fs_q   <= tick & at_origin;
            if (tick) begin
                en_q     <= pix_act;
                x_q      <= pix_act ? XW'(h_q) : '0;
                y_q      <= pix_act ? YW'(v_q) : '0;
                hs_pre_q <= h_sync_act;
                vs_pre_q <= v_sync_act;
            end
            // rgb_8 answers the request issued during the previous (tick) clock.
            if (tick_q) begin
                de_q <= en_q;
                hs_q <= hs_pre_q ? SYNC_POL : SYNC_IDLE;
                vs_q <= vs_pre_q ? SYNC_POL : SYNC_IDLE;
                r_q  <= en_q ? r_exp : '0;
                g_q  <= en_q ? g_exp : '0;
                b_q  <= en_q ? b_exp : '0;
            end
        end
    end

    assign bus.pix_tick    = tick_q;
    assign bus.frame_start = fs_q;
    assign bus.pixel_en    = en_q;
    assign bus.pixel_x     = x_q;
    assign bus.pixel_y     = y_q;
    assign bus.h_sync      = hs_q;
    assign bus.v_sync      = vs_q;
    assign bus.de_out      = de_q;
    assign bus.r_out       = r_q;
    assign bus.g_out       = g_q;
    assign bus.b_out       = b_q;
endmodule
